// File: rtl/hvac_if.sv
// hvac_sequencer sensor/actuator bundle.
// The master drives en/temp; the slave drives the actuator and status outputs.
interface hvac_if;
  logic       en;
  logic [4:0] temp;
  logic       heat_on;
  logic       cool_on;
  logic [1:0] state;
  logic       lockout;

  modport master (
    output en,
    output temp,
    input  heat_on,
    input  cool_on,
    input  state,
    input  lockout
  );

  modport slave (
    input  en,
    input  temp,
    output heat_on,
    output cool_on,
    output state,
    output lockout
  );
endinterface

// File: rtl/hvac_sequencer.sv
// Heater/cooler supervisor: sampled and debounced thresholds,
// minimum on-time and lockout between actuator runs.
module hvac_sequencer #(
  parameter int unsigned SAMPLE_DIV  = 4,
  parameter int unsigned MIN_ON      = 16,
  parameter int unsigned MIN_OFF     = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned HEAT_ON_TH  = 12,
  parameter int unsigned COOL_ON_TH  = 18,
  parameter int unsigned HEAT_OFF_TH = 20,
  parameter int unsigned COOL_OFF_TH = 14
) (
  input logic   clk,
  input logic   rst_n,
  hvac_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    COOL = 2'b01,
    HEAT = 2'b10,
    LOCK = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_HEAT = 2'd1,
    C_COOL = 2'd2,
    C_OFF  = 2'd3
  } cls_t;

  state_t           st;
  cls_t             cls;
  cls_t             prev_class;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] off_cnt;
  logic             off_req;
  logic             tick;
  logic             confirmed;
  logic             on_done;
  logic             off_done;
  logic [31:0]      t32;

  assign t32       = 32'(bus.temp);
  assign tick      = div_cnt == DIV_W'(SAMPLE_DIV - 1);
  assign confirmed = tick && (cls == prev_class)
                     && (cls != C_NONE);
  assign on_done   = on_cnt == CNT_W'(MIN_ON);
  assign off_done  = off_cnt == CNT_W'(MIN_OFF - 1);

  always_comb begin
    cls = C_NONE;
    unique case (st)
      IDLE: begin
        if (t32 <= HEAT_ON_TH)
          cls = C_HEAT;
        else if (t32 >= COOL_ON_TH)
          cls = C_COOL;
      end
      HEAT: if (t32 >= HEAT_OFF_TH) cls = C_OFF;
      COOL: if (t32 <= COOL_OFF_TH) cls = C_OFF;
      LOCK: cls = C_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      prev_class <= C_NONE;
      div_cnt    <= '0;
      on_cnt     <= '0;
      off_cnt    <= '0;
      off_req    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      unique case (st)
        IDLE: begin
          if (tick) begin
            if (confirmed && bus.en && cls == C_HEAT) begin
              st         <= HEAT;
              prev_class <= C_NONE;
              on_cnt     <= '0;
              off_req    <= 1'b0;
            end else if (confirmed && bus.en && cls == C_COOL) begin
              st         <= COOL;
              prev_class <= C_NONE;
              on_cnt     <= '0;
              off_req    <= 1'b0;
            end else begin
              prev_class <= cls;
            end
          end
        end
        HEAT, COOL: begin
          // en low bypasses the minimum on-time
          if (!bus.en || (off_req && on_done)) begin
            st         <= LOCK;
            prev_class <= C_NONE;
            off_cnt    <= '0;
            off_req    <= 1'b0;
          end else begin
            if (!on_done)
              on_cnt <= on_cnt + CNT_W'(1);
            if (tick) begin
              prev_class <= cls;
              if (confirmed)
                off_req <= 1'b1;
              else if (cls == C_NONE)
                off_req <= 1'b0;
            end
          end
        end
        LOCK: begin
          if (off_done) begin
            st         <= IDLE;
            prev_class <= C_NONE;
          end else begin
            off_cnt <= off_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.state   = st;
  assign bus.heat_on = st == HEAT;
  assign bus.cool_on = st == COOL;
  assign bus.lockout = st == LOCK;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer with hand-computed
// edge-by-edge expectations and an exclusivity monitor.
module tb_hvac_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   ec;
  logic [1:0] last_st;

  hvac_if hv ();

  hvac_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [3:0] obs,
                       input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic to_edge(input int t);
    while (ec < t) begin
      @(posedge clk);
      ec++;
    end
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [1:0] exp);
    check(tag, {2'b00, hv.state}, {2'b00, exp});
  endtask

  // heat_on/cool_on exclusion and no direct HEAT<->COOL step
  always @(negedge clk) begin
    if (rst_n) begin
      check("excl", {3'b000, hv.heat_on & hv.cool_on}, 4'h0);
      check("direct",
            {3'b000, (last_st == 2'b10 && hv.state == 2'b01) ||
                     (last_st == 2'b01 && hv.state == 2'b10)},
            4'h0);
      last_st = hv.state;
    end else begin
      last_st = 2'b00;
    end
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    ec      = 0;
    last_st = 2'b00;
    rst_n   = 1'b0;
    hv.en   = 1'b1;
    hv.temp = 5'd18;
    #3;
    chk_st("rst_state", 2'b00);
    check("rst_heat", {3'b0, hv.heat_on}, 4'h0);
    check("rst_cool", {3'b0, hv.cool_on}, 4'h0);
    check("rst_lock", {3'b0, hv.lockout}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ec    = 0;

    // steady cool demand at boundary 18
    to_edge(7);
    chk_st("cool_wait", 2'b00);
    to_edge(8);
    chk_st("cool_start", 2'b01);
    check("cool_on", {3'b0, hv.cool_on}, 4'h1);
    check("cool_heat", {3'b0, hv.heat_on}, 4'h0);

    // en drop forces immediate lockout
    hv.en = 1'b0;
    to_edge(9);
    chk_st("en_lock", 2'b11);
    check("en_cool_off", {3'b0, hv.cool_on}, 4'h0);
    check("en_lockout", {3'b0, hv.lockout}, 4'h1);
    to_edge(16);
    chk_st("lock_last", 2'b11);
    to_edge(17);
    chk_st("lock_done", 2'b00);
    hv.temp = 5'd31;
    to_edge(29);
    chk_st("idle_en0", 2'b00);

    // prev_class kept updating while en=0
    hv.en = 1'b1;
    to_edge(31);
    chk_st("en1_wait", 2'b00);
    to_edge(32);
    chk_st("en1_cool", 2'b01);

    // async reset mid-COOL
    to_edge(34);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cool", {3'b0, hv.cool_on}, 4'h0);
    chk_st("arst_state", 2'b00);
    check("arst_lock", {3'b0, hv.lockout}, 4'h0);
    hv.temp = 5'd12;
    @(negedge clk);
    rst_n = 1'b1;
    ec    = 0;

    // heat demand at boundary 12; first tick 4 cycles later
    to_edge(7);
    chk_st("heat_wait", 2'b00);
    to_edge(8);
    chk_st("heat_start", 2'b10);
    check("heat_on", {3'b0, hv.heat_on}, 4'h1);

    // early off request held until MIN_ON
    hv.temp = 5'd20;
    to_edge(24);
    chk_st("min_on_hold", 2'b10);
    check("min_on_heat", {3'b0, hv.heat_on}, 4'h1);
    to_edge(25);
    chk_st("min_on_stop", 2'b11);
    check("stop_heat", {3'b0, hv.heat_on}, 4'h0);
    to_edge(32);
    chk_st("lock2_last", 2'b11);
    to_edge(33);
    chk_st("lock2_done", 2'b00);

    // heat -> cool only through lockout
    to_edge(39);
    chk_st("h2c_wait", 2'b00);
    to_edge(40);
    chk_st("h2c_cool", 2'b01);

    hv.en = 1'b0;
    to_edge(41);
    chk_st("lock3", 2'b11);
    hv.en = 1'b1;
    to_edge(49);
    chk_st("lock3_done", 2'b00);

    // single-tick demand is not confirmed
    hv.temp = 5'd12;
    to_edge(52);
    hv.temp = 5'd15;
    to_edge(60);
    chk_st("glitch", 2'b00);

    // COOL off boundary 14; NONE tick clears a pending request
    hv.temp = 5'd31;
    to_edge(67);
    chk_st("cool2_wait", 2'b00);
    to_edge(68);
    chk_st("cool2_start", 2'b01);
    hv.temp = 5'd14;
    to_edge(76);
    hv.temp = 5'd15;
    to_edge(88);
    chk_st("offreq_clr", 2'b01);
    hv.temp = 5'd14;
    to_edge(96);
    chk_st("off_confirm", 2'b01);
    to_edge(97);
    chk_st("off_stop", 2'b11);
    to_edge(105);
    chk_st("lock4_done", 2'b00);

    // alternating demands never confirm
    hv.temp = 5'd5;
    to_edge(108);
    hv.temp = 5'd31;
    to_edge(112);
    hv.temp = 5'd5;
    to_edge(116);
    hv.temp = 5'd31;
    to_edge(120);
    hv.temp = 5'd5;
    to_edge(124);
    chk_st("alternate", 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hvac_sequencer.md
# hvac_sequencer

Clocked supervisor for the temperature-control FSM. Samples the 5-bit temperature at a fixed rate and debounces threshold crossings over two consecutive samples. Drives mutually exclusive heater/cooler enables with minimum on-time and minimum off-time (lockout) protection. Sits between the temperature sensor input and the heating/cooling actuators, and exports the 2-bit state code.

## Interface
- SAMPLE_DIV, 4: clock cycles between temperature samples (>=2)
- MIN_ON, 16: minimum cycles an actuator stays on once started (>=1)
- MIN_OFF, 8: cycles spent in lockout after an actuator stops (>=1)
- CNT_W, 8: width of on/off counters; must hold max(MIN_ON, MIN_OFF)
- HEAT_ON_TH, 12: sample <= this is a heat demand
- COOL_ON_TH, 18: sample >= this is a cool demand
- HEAT_OFF_TH, 20: in HEAT, sample >= this is an off request
- COOL_OFF_TH, 14: in COOL, sample <= this is an off request
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global enable; low forces actuators off
- temp  input  5  unsigned temperature, 0..31
- heat_on  output  1  heater enable
- cool_on  output  1  cooler enable
- state  output  2  00 IDLE, 01 COOL, 10 HEAT, 11 LOCKOUT
- lockout  output  1  high while state==LOCKOUT

## Operation
- Sample divider: div_cnt counts 0..SAMPLE_DIV-1 and wraps. tick is high in the cycle where div_cnt==SAMPLE_DIV-1. temp is compared only on tick.
- Classification per tick, with all comparisons unsigned and inclusive:
  - IDLE: HEAT-demand if temp<=HEAT_ON_TH, COOL-demand if temp>=COOL_ON_TH, else NONE.
  - HEAT: OFF if temp>=HEAT_OFF_TH, else NONE.
  - COOL: OFF if temp<=COOL_OFF_TH, else NONE.
- Debounce: prev_class register holds the last tick's class. A request is confirmed when the current class equals prev_class and is not NONE. prev_class clears to NONE on every state change.
- IDLE -> HEAT on a confirmed HEAT-demand tick, if en=1.
- IDLE -> COOL on a confirmed COOL-demand tick, if en=1.
- HEAT/COOL: on_cnt clears on entry and increments each cycle, saturating at MIN_ON. off_req sets on a confirmed OFF tick and clears on any NONE tick.
- HEAT/COOL -> LOCKOUT in the first cycle with off_req=1 and on_cnt==MIN_ON. A confirmation that arrives early is held until MIN_ON is met, unless a NONE tick clears it first.
- HEAT/COOL -> LOCKOUT immediately when en=0. This bypasses MIN_ON.
- LOCKOUT: off_cnt clears on entry and increments each cycle. At off_cnt==MIN_OFF-1 the next state is IDLE, regardless of en or temp. Samples taken during LOCKOUT are discarded.
- IDLE with en=0: stays IDLE and classification continues. A request confirmed while en=0 is ignored, and prev_class still updates.
- Outputs are decoded from the state register only:
  - heat_on = (state==HEAT)
  - cool_on = (state==COOL)
  - lockout = (state==LOCKOUT)
- heat_on and cool_on are never both high. There is no direct HEAT<->COOL path; every change of actuator passes through LOCKOUT.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, so heat_on=0, cool_on=0, lockout=0 and state=00. div_cnt, on_cnt, off_cnt clear to 0; prev_class=NONE; off_req=0. The first tick after release is SAMPLE_DIV cycles later.
- Reset asserted mid-HEAT/COOL drops the actuator asynchronously, with no lockout. This is an accepted exception.
- Start latency:
  - The state register updates on the edge ending the confirming tick cycle, and outputs follow in the same cycle.
  - Minimum delay from a steady demand to actuator on is 2 ticks; with a tick-aligned change, SAMPLE_DIV+1 cycles.
- Stop latency: max(second OFF tick, entry+MIN_ON cycles), plus 1 edge.
- en=0 in HEAT/COOL: the actuator is off in the cycle after en is sampled low.
- LOCKOUT lasts exactly MIN_OFF cycles.
- The divider free-runs across all states and is never reset by a state change.

## Test plan
- Reset, then hold temp=18, en=1. Required: state=01 and cool_on=1 after the 2nd tick (cycle 8). heat_on=0 throughout.
- Temp=12 on one tick only, then 15. Required: no transition; state stays 00.
- In HEAT, raise temp to 22 immediately after entry. Required: heat_on remains high until on_cnt reaches 16, then state=11 for exactly 8 cycles, then 00.
- In COOL, set en=0. Required: cool_on=0 the next cycle and state=11. After 8 cycles state=00, and state stays 00 while en=0 even with temp=31.
- Temp alternating 5/31 per tick, or HEAT->cool demand sequence. Required: no HEAT<->COOL transition without passing through 11; heat_on&cool_on never 1 (assertion).
- Assert rst_n=0 asynchronously mid-COOL. Required: outputs 0 immediately with no clock edge, state=00, and the first tick SAMPLE_DIV cycles after release.
